sa_input_skewer: RTL and testbench

//   Upstream feeder for a column of sa_cell instances. Accepts one NUM_ROWS-wide vector
//   of FP16 operands per valid/ready beat and buffers it in a FIFO. Replays vectors onto
//   the per-row left_in ports with systolic skew: row r lags row 0 by r cycles. After the

---
 rtl/sa_pkg.sv | 12 +
 rtl/sa_vec_fifo.sv | 49 ++++
 rtl/sa_input_skewer.sv | 118 +++++++++++
 tb/tb_sa_input_skewer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared types, constants and helpers for the systolic-array feeder blocks.
package sa_pkg;

    typedef enum logic [1:0] {SK_IDLE, SK_STREAM, SK_DRAIN} sk_state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    function automatic int lane_lo(input int r, input int dw);
        return r * dw;
    endfunction

endpackage

// File: rtl/sa_vec_fifo.sv
// sa_vec_fifo: synchronous FIFO with wrap-bit pointers and a registered occupancy count.
module sa_vec_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic push_ok, pop_ok;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d  = wptr_q + (AW+1)'(push_ok);
        rptr_d  = rptr_q + (AW+1)'(pop_ok);
        count_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sa_input_skewer.sv
// sa_input_skewer: buffers operand vectors and replays them onto the array rows with
// a one-cycle-per-row skew, flushing with zero bubbles and pulsing done at tile end.
module sa_input_skewer
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROWS   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                           in_last,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           start,
    input  logic                           stall,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] left_out,
    output logic [NUM_ROWS-1:0]            left_valid,
    output logic                           busy,
    output logic                           done
);
    localparam int DW  = DATA_WIDTH;
    localparam int NR  = NUM_ROWS;
    localparam int VW  = NR * DW;
    localparam int DCW = NR > 1 ? $clog2(NR) : 1;
    localparam logic [DCW-1:0] DRAIN_END = DCW'(NR >= 2 ? NR - 2 : 0);

    logic full, empty, pop, fifo_last;
    logic [VW-1:0] fifo_data;
    logic [VW:0] fifo_rdata;

    sa_vec_fifo #(.WIDTH(VW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata ({in_last, in_data}),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    assign {fifo_last, fifo_data} = fifo_rdata;
    assign in_ready = !full;

    sk_state_t state_q, state_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic done_q, done_d;

    assign pop  = state_q == SK_STREAM && !stall && !empty;
    assign busy = state_q != SK_IDLE;
    assign done = done_q && !stall;

    // A done raised while stalled is held until the first free cycle.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        done_d  = stall && done_q;
        if (!stall) begin
            if (state_q == SK_IDLE && start) state_d = SK_STREAM;
            if (pop && fifo_last) begin
                state_d = NR == 1 ? SK_IDLE : SK_DRAIN;
                drain_d = '0;
                done_d  = NR == 1;
            end
            if (state_q == SK_DRAIN) begin
                drain_d = drain_q + DCW'(1);
                if (drain_q == DRAIN_END) begin
                    state_d = SK_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SK_IDLE;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    for (genvar r = 0; r < NR; r++) begin : g_lane
        logic [DW:0] inj, out_d, out_q;
        assign inj = pop ? {1'b1, fifo_data[lane_lo(r, DW) +: DW]} : {1'b0, DW'(FP16_ZERO)};
        if (r == 0) begin : g_direct
            assign out_d = inj;
        end else begin : g_delay
            logic [DW:0] dl_q [r];
            logic [DW:0] dl_d [r];
            always_comb begin
                dl_d[0] = inj;
                for (int k = 1; k < r; k++) dl_d[k] = dl_q[k-1];
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) dl_q[k] <= '0;
                end else if (!stall) begin
                    dl_q <= dl_d;
                end
            end
            assign out_d = dl_q[r-1];
        end
        always_ff @(posedge clk) begin
            if (rst) out_q <= '0;
            else if (!stall) out_q <= out_d;
        end
        assign left_out[lane_lo(r, DW) +: DW] = out_q[DW-1:0];
        assign left_valid[r] = out_q[DW];
    end

endmodule

// File: tb/tb_sa_input_skewer.sv
// tb_sa_input_skewer: directed table-driven bench for the systolic input skewer.
module tb_sa_input_skewer;

    logic        clk = 1'b0;
    logic        rst, in_last, in_valid, start, stall;
    logic [63:0] in_data;
    logic        in_ready, busy, done;
    logic [63:0] left_out;
    logic [3:0]  left_valid;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] V1 = 64'h4400_4200_4000_3C00;
    localparam logic [63:0] V2 = 64'h4800_4700_4600_4500;

    sa_input_skewer #(.DATA_WIDTH(16), .NUM_ROWS(4), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .stall      (stall),
        .left_out   (left_out),
        .left_valid (left_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, last, st, sl;
        logic [63:0] d, e_out;
        logic [3:0]  e_lv;
        logic        e_done, e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, last, st, sl, input logic [63:0] d, eo,
                       input logic [3:0] elv, input logic ed, eb);
        vec_t x;
        x.v = v; x.last = last; x.st = st; x.sl = sl; x.d = d;
        x.e_out = eo; x.e_lv = elv; x.e_done = ed; x.e_busy = eb;
        tbl.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    function automatic logic [63:0] mkvec(input int i);
        logic [63:0] v;
        for (int r = 0; r < 4; r++) v[r*16 +: 16] = 16'(16'h1000 * (r + 1) + i);
        return v;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0; stall = 1'b0; in_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] t;
        int n;
        int done_seen;
        rst = 1'b1;
        idle_inputs();
        // Tile of two vectors, no stall.
        add(1, 0, 0, 0, V1, 64'h0, 4'b0000, 0, 0);
        add(1, 1, 0, 0, V2, 64'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0,  64'h0, 4'b0000, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_0000_3C00, 4'b0001, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_4000_4500, 4'b0011, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_4200_4600_0000, 4'b0110, 0, 1);
        add(0, 0, 0, 0, 0,  64'h4400_4700_0000_0000, 4'b1100, 0, 1);
        add(0, 0, 0, 0, 0,  64'h4800_0000_0000_0000, 4'b1000, 1, 0);
        add(0, 0, 0, 0, 0,  64'h0, 4'b0000, 0, 0);
        // Same tile with three stalled cycles after the first pop.
        add(1, 0, 0, 0, V1, 64'h0, 4'b0000, 0, 0);
        add(1, 1, 0, 0, V2, 64'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0,  64'h0, 4'b0000, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_0000_3C00, 4'b0001, 0, 1);
        add(0, 0, 0, 1, 0,  64'h0000_0000_0000_3C00, 4'b0001, 0, 1);
        add(0, 0, 0, 1, 0,  64'h0000_0000_0000_3C00, 4'b0001, 0, 1);
        add(0, 0, 0, 1, 0,  64'h0000_0000_0000_3C00, 4'b0001, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_4000_4500, 4'b0011, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_4200_4600_0000, 4'b0110, 0, 1);
        add(0, 0, 0, 0, 0,  64'h4400_4700_0000_0000, 4'b1100, 0, 1);
        add(0, 0, 0, 0, 0,  64'h4800_0000_0000_0000, 4'b1000, 1, 0);
        add(0, 0, 0, 0, 0,  64'h0, 4'b0000, 0, 0);
        // Underrun: last vector arrives four cycles after start.
        add(1, 0, 0, 0, V1, 64'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0,  64'h0, 4'b0000, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_0000_3C00, 4'b0001, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_4000_0000, 4'b0010, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_4200_0000_0000, 4'b0100, 0, 1);
        add(1, 1, 0, 0, V2, 64'h4400_0000_0000_0000, 4'b1000, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_0000_4500, 4'b0001, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_0000_4600_0000, 4'b0010, 0, 1);
        add(0, 0, 0, 0, 0,  64'h0000_4700_0000_0000, 4'b0100, 0, 1);
        add(0, 0, 0, 0, 0,  64'h4800_0000_0000_0000, 4'b1000, 1, 0);
        add(0, 0, 0, 0, 0,  64'h0, 4'b0000, 0, 0);

        repeat (3) step();
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst left_valid", 64'(left_valid), 64'd0);
        chk("rst left_out", left_out, 64'd0);
        chk("rst done", 64'(done), 64'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            in_valid = tbl[i].v; in_last = tbl[i].last; start = tbl[i].st;
            stall = tbl[i].sl; in_data = tbl[i].d;
            step();
            chk($sformatf("row%0d left_out", i), left_out, tbl[i].e_out);
            chk($sformatf("row%0d left_valid", i), 64'(left_valid), 64'(tbl[i].e_lv));
            chk($sformatf("row%0d done", i), 64'(done), 64'(tbl[i].e_done));
            chk($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'd1);
        end
        idle_inputs();

        // Fill the FIFO to capacity, then try a ninth push.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = mkvec(i); in_last = (i == 8);
            step();
        end
        chk("fill in_ready after 8", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF_CAFE_F00D; in_last = 1'b0;
        step();
        chk("full in_ready hold1", 64'(in_ready), 64'd0);
        step();
        chk("full in_ready hold2", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fill busy", 64'(busy), 64'd1);
        chk("fill in_ready pre-pop", 64'(in_ready), 64'd0);
        step();
        chk("fill in_ready post-pop", 64'(in_ready), 64'd1);
        t = mkvec(1);
        chk("fill row0 v1", 64'(left_out[15:0]), 64'(t[15:0]));
        for (int i = 2; i <= 8; i++) begin
            step();
            t = mkvec(i);
            chk($sformatf("fill row0 v%0d", i), 64'(left_out[15:0]), 64'(t[15:0]));
        end
        n = 0;
        while (!done && n < 10) begin
            step();
            n++;
        end
        chk("fill done latency", 64'(n), 64'd3);
        t = mkvec(8);
        chk("fill row3 at done", 64'(left_out[63:48]), 64'(t[63:48]));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ninth vector absent", 64'(left_valid), 64'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset while draining the skew.
        in_valid = 1'b1; in_data = V1; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("drain busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        chk("drain rst left_out", left_out, 64'd0);
        chk("drain rst left_valid", 64'(left_valid), 64'd0);
        chk("drain rst busy", 64'(busy), 64'd0);
        chk("drain rst done", 64'(done), 64'd0);
        chk("drain rst in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) done_seen++;
        end
        chk("no done after rst", 64'(done_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
